// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational Alu16 between two requesters.
// An accepted op {a, b, c} is registered onto the ALU inputs and settles for one
// cycle. The ALU result and flags are then captured and returned on the owner's
// response channel. Grants are round-robin on contention, with one op in flight.
// Optional build macro: ALU_ARB_OPCHECK_EN. When it is defined, control codes
// outside the implemented ALU set are rejected. A rejected op gets an error
// response after 1 cycle and does not touch the ALU.
module alu_arbiter #(
  parameter int WIDTH  = 16,
  parameter int CTRL_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_c,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [WIDTH-1:0]  rsp0_data,
  output logic              rsp0_zr,
  output logic              rsp0_ng,
  output logic              rsp0_err,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_c,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp1_data,
  output logic              rsp1_zr,
  output logic              rsp1_ng,
  output logic              rsp1_err,
  // shared ALU
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_c,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Control code that makes the ALU output constant 0; parked there after reset.
  localparam logic [CTRL_W-1:0] ALU_C_ZERO = CTRL_W'(6'b101010);
  localparam logic [WIDTH-1:0]  DATA_ZERO  = {WIDTH{1'b0}};

`ifdef ALU_ARB_OPCHECK_EN
  // Codes the Alu16 actually implements; anything else is rejected.
  function automatic logic op_supported(input logic [CTRL_W-1:0] code);
    logic ok;
    case (code)
      CTRL_W'(6'b101010),
      CTRL_W'(6'b111111),
      CTRL_W'(6'b111010),
      CTRL_W'(6'b001100),
      CTRL_W'(6'b110000),
      CTRL_W'(6'b001111),
      CTRL_W'(6'b110011): ok = 1'b1;
      default:            ok = 1'b0;
    endcase
    return ok;
  endfunction
`endif

  state_t              state_r;
  logic                owner_r;
  logic                last_grant_r;
  logic [WIDTH-1:0]    alu_a_r;
  logic [WIDTH-1:0]    alu_b_r;
  logic [CTRL_W-1:0]   alu_c_r;
  logic [1:0]          rsp_valid_r;
  logic [1:0][WIDTH-1:0] rsp_data_r;
  logic [1:0]          rsp_zr_r;
  logic [1:0]          rsp_ng_r;
  logic [1:0]          rsp_err_r;

  logic                grant_s;
  logic                any_valid_s;
  logic                accept_s;
  logic                reject_s;
  logic                own_ready_s;
  logic [WIDTH-1:0]    sel_a_s;
  logic [WIDTH-1:0]    sel_b_s;
  logic [CTRL_W-1:0]   sel_c_s;

  // Round-robin grant: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant_s     = 1'b0;
    any_valid_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s     = ~last_grant_r;
      any_valid_s = 1'b1;
    end else if (req0_valid) begin
      grant_s     = 1'b0;
      any_valid_s = 1'b1;
    end else if (req1_valid) begin
      grant_s     = 1'b1;
      any_valid_s = 1'b1;
    end else begin
      grant_s     = 1'b0;
      any_valid_s = 1'b0;
    end
  end

  // Operand mux for the granted requester, plus the handshake and ready decode.
  always_comb begin
    sel_a_s  = req0_a;
    sel_b_s  = req0_b;
    sel_c_s  = req0_c;
    if (grant_s) begin
      sel_a_s = req1_a;
      sel_b_s = req1_b;
      sel_c_s = req1_c;
    end else begin
      sel_a_s = req0_a;
      sel_b_s = req0_b;
      sel_c_s = req0_c;
    end
    // Nothing is accepted while reset is asserted, even though the FSM is in IDLE.
    accept_s   = (state_r == ST_IDLE) && any_valid_s && !reset;
    req0_ready = accept_s && !grant_s;
    req1_ready = accept_s && grant_s;
  end

`ifdef ALU_ARB_OPCHECK_EN
  assign reject_s = ~op_supported(sel_c_s);
`else
  assign reject_s = 1'b0;
`endif

  // The owner's consume strobe closes the response phase.
  always_comb begin
    own_ready_s = 1'b0;
    if (owner_r) begin
      own_ready_s = rsp1_ready;
    end else begin
      own_ready_s = rsp0_ready;
    end
  end

  // Arbiter FSM: IDLE accepts, ISSUE lets the ALU settle and captures, RESP holds until consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      owner_r       <= 1'b0;
      last_grant_r  <= 1'b1;
      alu_a_r       <= DATA_ZERO;
      alu_b_r       <= DATA_ZERO;
      alu_c_r       <= ALU_C_ZERO;
      rsp_valid_r   <= 2'b00;
      rsp_data_r[0] <= DATA_ZERO;
      rsp_data_r[1] <= DATA_ZERO;
      rsp_zr_r      <= 2'b00;
      rsp_ng_r      <= 2'b00;
      rsp_err_r     <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            owner_r      <= grant_s;
            last_grant_r <= grant_s;
            if (reject_s) begin
              // Rejected code: the ALU keeps its inputs, and the error is answered next cycle.
              // Data and flags are already 0 because every response clears them on completion.
              rsp_valid_r[grant_s] <= 1'b1;
              rsp_err_r[grant_s]   <= 1'b1;
              state_r              <= ST_RESP;
            end else begin
              alu_a_r <= sel_a_s;
              alu_b_r <= sel_b_s;
              alu_c_r <= sel_c_s;
              state_r <= ST_ISSUE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // The ALU inputs have been stable for a full cycle, so its outputs are settled.
          // The flags are taken from the ALU as it reports them, never recomputed here.
          rsp_valid_r[owner_r] <= 1'b1;
          rsp_data_r[owner_r]  <= alu_out;
          rsp_zr_r[owner_r]    <= alu_zr;
          rsp_ng_r[owner_r]    <= alu_ng;
          state_r              <= ST_RESP;
        end
        ST_RESP: begin
          if (own_ready_s) begin
            // Clear everything so that a channel which does not own an op reads as all zero.
            rsp_valid_r   <= 2'b00;
            rsp_data_r[0] <= DATA_ZERO;
            rsp_data_r[1] <= DATA_ZERO;
            rsp_zr_r      <= 2'b00;
            rsp_ng_r      <= 2'b00;
            rsp_err_r     <= 2'b00;
            state_r       <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          rsp_valid_r   <= 2'b00;
          rsp_data_r[0] <= DATA_ZERO;
          rsp_data_r[1] <= DATA_ZERO;
          rsp_zr_r      <= 2'b00;
          rsp_ng_r      <= 2'b00;
          rsp_err_r     <= 2'b00;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_c      = alu_c_r;

  assign rsp0_valid = rsp_valid_r[0];
  assign rsp0_data  = rsp_data_r[0];
  assign rsp0_zr    = rsp_zr_r[0];
  assign rsp0_ng    = rsp_ng_r[0];
  assign rsp0_err   = rsp_err_r[0];

  assign rsp1_valid = rsp_valid_r[1];
  assign rsp1_data  = rsp_data_r[1];
  assign rsp1_zr    = rsp_zr_r[1];
  assign rsp1_ng    = rsp_ng_r[1];
  assign rsp1_err   = rsp_err_r[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed, table-driven bench for alu_arbiter.
// A behavioural Hack-style ALU stands in for the Alu16 instance.
module tb_alu_arbiter;

  localparam int W  = 16;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [W-1:0]  req0_a, req0_b, rsp0_data;
  logic [CW-1:0] req0_c;
  logic          rsp0_zr, rsp0_ng, rsp0_err;
  logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0]  req1_a, req1_b, rsp1_data;
  logic [CW-1:0] req1_c;
  logic          rsp1_zr, rsp1_ng, rsp1_err;
  logic [W-1:0]  alu_a, alu_b, alu_out;
  logic [CW-1:0] alu_c;
  logic          alu_zr, alu_ng;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          v0;
    logic          v1;
    logic [W-1:0]  a0;
    logic [W-1:0]  b0;
    logic [CW-1:0] c0;
    logic [W-1:0]  a1;
    logic [W-1:0]  b1;
    logic [CW-1:0] c1;
    logic          own;
    logic [W-1:0]  data;
    logic          zr;
    logic          ng;
  } vec_t;

  vec_t vecs[8];

  alu_arbiter #(.WIDTH(W), .CTRL_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_zr(rsp0_zr),
    .rsp0_ng(rsp0_ng), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_zr(rsp1_zr),
    .rsp1_ng(rsp1_ng), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
  );

  always #5 clk = ~clk;

  // Reference ALU with control order {zx,nx,zy,ny,f,no}.
  function automatic logic [W-1:0] hack_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [CW-1:0] c);
    logic [W-1:0] x, y, o;
    x = c[5] ? 16'h0000 : a;
    x = c[4] ? ~x : x;
    y = c[3] ? 16'h0000 : b;
    y = c[2] ? ~y : y;
    o = c[1] ? (x + y) : (x & y);
    o = c[0] ? ~o : o;
    return o;
  endfunction

  // Combinational ALU model.
  always_comb begin
    alu_out = hack_alu(alu_a, alu_b, alu_c);
    alu_zr  = (alu_out == 16'h0000);
    alu_ng  = alu_out[W-1];
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One table op: accept in IDLE, ISSUE, RESP, consume.
  task automatic run_vec(input vec_t v, input int idx);
    logic [CW-1:0] exp_c;
    exp_c = v.own ? v.c1 : v.c0;
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_c = v.c0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_c = v.c1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    chk1($sformatf("v%0d req0_ready", idx), req0_ready, !v.own);
    chk1($sformatf("v%0d req1_ready", idx), req1_ready, v.own);
    tick;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk16($sformatf("v%0d alu_c", idx), 16'(alu_c), 16'(exp_c));
    chk1($sformatf("v%0d no_early_rsp", idx), rsp0_valid | rsp1_valid, 1'b0);
    tick;
    chk1($sformatf("v%0d own_valid", idx), v.own ? rsp1_valid : rsp0_valid, 1'b1);
    chk16($sformatf("v%0d own_data", idx), v.own ? rsp1_data : rsp0_data, v.data);
    chk1($sformatf("v%0d own_zr", idx), v.own ? rsp1_zr : rsp0_zr, v.zr);
    chk1($sformatf("v%0d own_ng", idx), v.own ? rsp1_ng : rsp0_ng, v.ng);
    chk1($sformatf("v%0d own_err", idx), v.own ? rsp1_err : rsp0_err, 1'b0);
    chk1($sformatf("v%0d other_valid", idx), v.own ? rsp0_valid : rsp1_valid, 1'b0);
    chk16($sformatf("v%0d other_data", idx), v.own ? rsp0_data : rsp1_data, 16'h0000);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick;
    chk1($sformatf("v%0d rsp_done", idx), rsp0_valid | rsp1_valid, 1'b0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  initial begin
    //          v0    v1    a0        b0        c0         a1        b1        c1         own   data      zr    ng
    vecs[0] = '{1'b1, 1'b0, 16'h0005, 16'h1234, 6'b001100, 16'h0000, 16'h0000, 6'b101010, 1'b0, 16'h0005, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 16'h0042, 16'h0000, 6'b001100, 16'h0003, 16'h0000, 6'b001111, 1'b1, 16'hFFFD, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 6'b111111, 16'h0009, 16'h0000, 6'b001100, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 16'h0077, 16'h0000, 6'b001100, 16'h0000, 16'h8000, 6'b110000, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 6'b001100, 16'h1111, 16'h2222, 6'b101010, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 16'h1234, 16'h5678, 6'b111010, 16'h0001, 16'h0000, 6'b001100, 1'b0, 16'hFFFF, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 16'h0000, 16'h0002, 6'b110011, 16'h0000, 16'h0000, 6'b101010, 1'b0, 16'hFFFE, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 16'h0055, 16'h0000, 6'b001111, 16'h0000, 16'h0000, 6'b001100, 1'b1, 16'h0000, 1'b1, 1'b0};

    reset = 1'b1;
    req0_valid = 1'b0; req0_a = 16'h0000; req0_b = 16'h0000; req0_c = 6'b000000;
    req1_valid = 1'b0; req1_a = 16'h0000; req1_b = 16'h0000; req1_c = 6'b000000;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick;
    tick;
    // No ready while reset is held, even with a valid request.
    req0_valid = 1'b1;
    #1;
    chk1("reset req0_ready", req0_ready, 1'b0);
    tick;
    reset = 1'b0;
    req0_valid = 1'b0;
    #1;
    chk1("reset rsp0_valid", rsp0_valid, 1'b0);
    chk1("reset rsp1_valid", rsp1_valid, 1'b0);
    chk16("reset rsp0_data", rsp0_data, 16'h0000);
    chk16("reset alu_a", alu_a, 16'h0000);
    chk16("reset alu_b", alu_b, 16'h0000);
    chk16("reset alu_c", 16'(alu_c), 16'h002A);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    // rsp0_ready and req1_valid in the same RESP cycle.
    req0_valid = 1'b1; req0_a = 16'h00AA; req0_b = 16'h0000; req0_c = 6'b001100;
    #1;
    chk1("s3 req0_ready", req0_ready, 1'b1);
    tick;
    req0_valid = 1'b0;
    tick;
    rsp0_ready = 1'b1;
    req1_valid = 1'b1; req1_a = 16'h0003; req1_b = 16'h0000; req1_c = 6'b001111;
    #1;
    chk1("s3 rsp0_valid", rsp0_valid, 1'b1);
    chk16("s3 rsp0_data", rsp0_data, 16'h00AA);
    chk1("s3 req1_ready in RESP", req1_ready, 1'b0);
    tick;
    rsp0_ready = 1'b0;
    chk1("s3 rsp0_dropped", rsp0_valid, 1'b0);
    chk1("s3 req1_ready next", req1_ready, 1'b1);
    tick;
    req1_valid = 1'b0;
    tick;
    chk1("s3 rsp1_valid", rsp1_valid, 1'b1);
    chk1("s3 rsp0_no_dup", rsp0_valid, 1'b0);

    // Response back-pressure: rsp1_ready held low for 5 cycles, with req0 waiting.
    req0_valid = 1'b1; req0_a = 16'h0001; req0_c = 6'b001100;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk1($sformatf("hold%0d rsp1_valid", k), rsp1_valid, 1'b1);
      chk16($sformatf("hold%0d rsp1_data", k), rsp1_data, 16'hFFFD);
      chk1($sformatf("hold%0d rsp1_ng", k), rsp1_ng, 1'b1);
      chk1($sformatf("hold%0d req0_ready", k), req0_ready, 1'b0);
      tick;
    end
    rsp1_ready = 1'b1;
    tick;
    rsp1_ready = 1'b0;
    chk1("hold rsp1_done", rsp1_valid, 1'b0);
    chk1("hold req0_ready idle", req0_ready, 1'b1);
    // Withdrawing valid without a handshake is legal, and nothing is accepted.
    req0_valid = 1'b0;
    #1;
    chk1("drop req0_ready", req0_ready, 1'b0);
    tick;
    tick;
    chk1("drop no rsp0", rsp0_valid, 1'b0);

    // Reset while an op is in ISSUE.
    req0_valid = 1'b1; req0_a = 16'h0011; req0_c = 6'b001111;
    #1;
    tick;
    req0_valid = 1'b0;
    reset = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk1("rst_issue req1_ready", req1_ready, 1'b0);
    tick;
    reset = 1'b0;
    req1_valid = 1'b0;
    chk1("rst_issue rsp0_valid", rsp0_valid, 1'b0);
    chk1("rst_issue rsp1_valid", rsp1_valid, 1'b0);
    chk16("rst_issue alu_c", 16'(alu_c), 16'h002A);
    chk16("rst_issue alu_a", alu_a, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk1($sformatf("rst_issue late%0d", k), rsp0_valid | rsp1_valid, 1'b0);
    end

    // Both requesters valid from reset: grants alternate 0,1,0,1.
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h0100; req0_b = 16'h0000; req0_c = 6'b001100;
    req1_valid = 1'b1; req1_a = 16'h0003; req1_b = 16'h0000; req1_c = 6'b001111;
    for (int k = 0; k < 4; k++) begin
      logic own;
      own = (k % 2) == 1;
      #1;
      chk1($sformatf("rr%0d req0_ready", k), req0_ready, !own);
      chk1($sformatf("rr%0d req1_ready", k), req1_ready, own);
      tick;
      chk1($sformatf("rr%0d busy", k), req0_ready | req1_ready, 1'b0);
      tick;
      chk1($sformatf("rr%0d own_valid", k), own ? rsp1_valid : rsp0_valid, 1'b1);
      chk16($sformatf("rr%0d own_data", k), own ? rsp1_data : rsp0_data, own ? 16'hFFFD : 16'h0100);
      chk1($sformatf("rr%0d other_valid", k), own ? rsp0_valid : rsp1_valid, 1'b0);
      tick;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Code outside the implemented set.
    req0_valid = 1'b1; req0_a = 16'h0007; req0_b = 16'h0009; req0_c = 6'b000010;
    #1;
    chk1("opchk req0_ready", req0_ready, 1'b1);
    tick;
    req0_valid = 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
    chk1("opchk rsp0_valid", rsp0_valid, 1'b1);
    chk1("opchk rsp0_err", rsp0_err, 1'b1);
    chk16("opchk rsp0_data", rsp0_data, 16'h0000);
    chk1("opchk rsp0_zr", rsp0_zr, 1'b0);
    chk16("opchk alu_c kept", 16'(alu_c), 16'h000F);
    chk16("opchk alu_a kept", alu_a, 16'h0003);
`else
    chk1("opchk early rsp0", rsp0_valid, 1'b0);
    chk16("opchk alu_c", 16'(alu_c), 16'h0002);
    tick;
    chk1("opchk rsp0_valid", rsp0_valid, 1'b1);
    chk1("opchk rsp0_err", rsp0_err, 1'b0);
    chk16("opchk rsp0_data", rsp0_data, 16'h0010);
`endif
    rsp0_ready = 1'b1;
    tick;
    rsp0_ready = 1'b0;
    chk1("opchk rsp0_done", rsp0_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
